// File: rtl/cpu_pkg.sv
// Shared CPU datapath definitions.
// Provides the data/address widths, the register count and the word and
// register-address types used on the register file ports.
package cpu_pkg;

    localparam int DATA_W   = 16;
    localparam int ADDR_W   = 4;
    localparam int NUM_REGS = 2 ** ADDR_W;

    typedef logic [DATA_W-1:0] word_t;
    typedef logic [ADDR_W-1:0] reg_addr_t;

endpackage : cpu_pkg

// File: rtl/reg_file_if.sv
// Register file access bundle between decode/execute and the register file.
// Signals:
//   wre  - write enable for port 3 (write lands on the rising clk edge)
//   a1   - read address, port 1
//   a2   - read address, port 2
//   a3   - read address, port 3, and write address when wre=1
//   wd3  - write-back data
//   rd1  - contents of entry a1 (combinational)
//   rd2  - contents of entry a2 (combinational)
//   rd3  - contents of entry a3 (combinational)
// There is no valid/ready handshake: a write is a single-cycle command
// qualified only by wre, and every read is always valid.
// Modports:
//   master - the datapath side, drives addresses/data, receives read data
//   slave  - the register file side
interface reg_file_if;
    import cpu_pkg::*;

    logic      wre;
    reg_addr_t a1;
    reg_addr_t a2;
    reg_addr_t a3;
    word_t     wd3;
    word_t     rd1;
    word_t     rd2;
    word_t     rd3;

    modport master (
        output wre, a1, a2, a3, wd3,
        input  rd1, rd2, rd3
    );

    modport slave (
        input  wre, a1, a2, a3, wd3,
        output rd1, rd2, rd3
    );

endinterface : reg_file_if

// File: rtl/reg_file_read_port.sv
// One combinational read port of the register file: a NUM_REGS:1 word mux.
// Ports:
//   regs - the full storage array
//   addr - entry select
//   data - selected entry, zero latency
module reg_file_read_port
    import cpu_pkg::*;
(
    input  word_t     regs [NUM_REGS],
    input  reg_addr_t addr,
    output word_t     data
);

    always_comb begin
        data = regs[addr];
    end

endmodule : reg_file_read_port

// File: rtl/reg_file.sv
// General-purpose register file: NUM_REGS entries of DATA_W bits, three
// asynchronous read ports and one synchronous write port sharing address a3.
// Ports:
//   clk   - system clock, writes occur on its rising edge
//   rst_n - asynchronous active-low reset, clears every entry
//   bus   - reg_file_if slave modport (wre, a1..a3, wd3, rd1..rd3)
// Reads are not bypassed: a port addressing the entry being written shows
// the old value until the edge and the new value right after it.
// Entry 0 is an ordinary writable register.
module reg_file
    import cpu_pkg::*;
(
    input  logic         clk,
    input  logic         rst_n,
    reg_file_if.slave    bus
);

    word_t regs [NUM_REGS];

    // Write decode compares a3 against each index. An unknown a3 makes every
    // compare unknown, so no entry is updated rather than a random one.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs[i] <= '0;
            end
        end else if (bus.wre) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                if (bus.a3 == reg_addr_t'(i)) begin
                    regs[i] <= bus.wd3;
                end
            end
        end
    end

    // Flag an unknown write address while a write is requested.
    always @(posedge clk) begin
        if (rst_n && bus.wre) begin
            a3_known_on_write: assert (!$isunknown(bus.a3));
        end
    end

    reg_file_read_port u_rp1 (
        .regs (regs),
        .addr (bus.a1),
        .data (bus.rd1)
    );

    reg_file_read_port u_rp2 (
        .regs (regs),
        .addr (bus.a2),
        .data (bus.rd2)
    );

    reg_file_read_port u_rp3 (
        .regs (regs),
        .addr (bus.a3),
        .data (bus.rd3)
    );

endmodule : reg_file

// File: tb/tb_reg_file.sv
// Self-checking bench for reg_file. Drivers compute the expected read data
// from a plain array model and push it into exp_q; a separate monitor pops
// and compares against rd1/rd2/rd3.
module tb_reg_file;
    import cpu_pkg::*;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    reg_file_if bus ();

    reg_file dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // ---------------- reference model + scoreboard ----------------
    word_t                 model [NUM_REGS];
    logic [3*DATA_W-1:0]   exp_q [$];
    string                 name_q [$];
    int                    tests = 0;
    int                    fails = 0;
    event                  chk_ev;
    event                  chk_done;

    task automatic model_clear();
        for (int i = 0; i < NUM_REGS; i++) model[i] = '0;
    endtask

    // ---------------- monitor ----------------
    initial begin : monitor
        logic [3*DATA_W-1:0] exp_v;
        logic [3*DATA_W-1:0] act_v;
        string               nm;
        forever begin
            @(chk_ev);
            tests++;
            if (exp_q.size() == 0) begin
                fails++;
                $display("FAIL scoreboard: read observed with no expected entry queued");
            end else begin
                exp_v = exp_q.pop_front();
                nm    = name_q.pop_front();
                act_v = {bus.rd1, bus.rd2, bus.rd3};
                if (act_v !== exp_v) begin
                    fails++;
                    $display("FAIL %s: a1/a2/a3=%0d/%0d/%0d got rd1/rd2/rd3=%h/%h/%h expected %h/%h/%h",
                             nm, bus.a1, bus.a2, bus.a3,
                             act_v[47:32], act_v[31:16], act_v[15:0],
                             exp_v[47:32], exp_v[31:16], exp_v[15:0]);
                end
            end
            -> chk_done;
        end
    end

    // ---------------- driver tasks ----------------
    // Apply read addresses now, queue the model's answer, let the monitor compare.
    task automatic check_now(input string nm, input reg_addr_t x1,
                             input reg_addr_t x2, input reg_addr_t x3);
        bus.a1 = x1;
        bus.a2 = x2;
        bus.a3 = x3;
        #1;
        exp_q.push_back({model[x1], model[x2], model[x3]});
        name_q.push_back(nm);
        -> chk_ev;
        @(chk_done);
    endtask

    task automatic check(input string nm, input reg_addr_t x1,
                         input reg_addr_t x2, input reg_addr_t x3);
        @(negedge clk);
        check_now(nm, x1, x2, x3);
    endtask

    // One write on the next rising edge; wre is dropped just after the edge.
    task automatic write_reg(input reg_addr_t addr, input word_t data);
        @(negedge clk);
        bus.wre = 1'b1;
        bus.a3  = addr;
        bus.wd3 = data;
        @(posedge clk);
        if (rst_n) model[addr] = data;
        #1;
        bus.wre = 1'b0;
    endtask

    // ---------------- watchdog ----------------
    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation time limit reached, %0d tests run", tests);
        $fatal(1, "watchdog expired");
    end

    // ---------------- stimulus ----------------
    initial begin : stimulus
        bus.wre = 1'b0;
        bus.a1  = '0;
        bus.a2  = '0;
        bus.a3  = '0;
        bus.wd3 = '0;
        rst_n   = 1'b0;
        model_clear();

        // Reset held for two cycles, then released.
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        check("reset_state", 4'd0, 4'd1, 4'd2);

        // Sequential writes on consecutive edges.
        write_reg(4'd0, 16'hABCD);
        write_reg(4'd1, 16'h29CA);
        write_reg(4'd2, 16'hC11F);
        check("seq_writes", 4'd0, 4'd1, 4'd2);
        check("seq_writes_swap", 4'd2, 4'd0, 4'd1);

        // Write disabled: three edges with wre=0 leave entry 5 untouched.
        @(negedge clk);
        bus.wre = 1'b0;
        bus.a3  = 4'd5;
        bus.wd3 = 16'hFFFF;
        repeat (3) @(posedge clk);
        check("write_disabled", 4'd5, 4'd5, 4'd5);

        // Read during write: old value before the edge, new value after.
        @(negedge clk);
        bus.wre = 1'b1;
        bus.wd3 = 16'h1234;
        check_now("rdw_before_edge", 4'd7, 4'd2, 4'd7);
        @(posedge clk);
        model[7] = 16'h1234;
        #1;
        bus.wre = 1'b0;
        check_now("rdw_after_edge", 4'd7, 4'd2, 4'd7);

        // Async reset between edges after loading every entry.
        for (int i = 0; i < NUM_REGS; i++) write_reg(reg_addr_t'(i), word_t'(16'h1000 + i));
        check("loaded", 4'd0, 4'd15, 4'd8);
        @(negedge clk);
        #1;
        rst_n   = 1'b0;
        bus.wre = 1'b1;
        bus.wd3 = 16'hBEEF;
        model_clear();
        check_now("async_reset_now", 4'd0, 4'd15, 4'd3);
        @(posedge clk);
        #1;
        check_now("write_in_reset", 4'd3, 4'd3, 4'd3);
        @(negedge clk);
        bus.wre = 1'b0;
        rst_n   = 1'b1;
        check_now("after_release", 4'd3, 4'd9, 4'd15);

        // Entry 0 is writable like any other.
        write_reg(4'd0, 16'h5A5A);
        check("entry0_writable", 4'd0, 4'd1, 4'd0);

        // Sweep: entry i <= 16'hFFFF - i, read back through every port.
        for (int i = 0; i < NUM_REGS; i++) write_reg(reg_addr_t'(i), word_t'(16'hFFFF - i));
        for (int i = 0; i < NUM_REGS; i++) begin
            check("sweep_same", reg_addr_t'(i), reg_addr_t'(i), reg_addr_t'(i));
            check("sweep_mixed", reg_addr_t'(i), reg_addr_t'(NUM_REGS - 1 - i),
                  reg_addr_t'((i + 5) % NUM_REGS));
        end

        // Random mix of writes and reads, including equal addresses.
        repeat (200) begin
            if ($urandom_range(0, 1) == 1) begin
                write_reg(reg_addr_t'($urandom_range(0, NUM_REGS - 1)), word_t'($urandom));
            end else begin
                check("random_read",
                      reg_addr_t'($urandom_range(0, NUM_REGS - 1)),
                      reg_addr_t'($urandom_range(0, NUM_REGS - 1)),
                      reg_addr_t'($urandom_range(0, NUM_REGS - 1)));
            end
        end

        // Final full readback.
        for (int i = 0; i < NUM_REGS; i++) begin
            check("final_readback", reg_addr_t'(i), reg_addr_t'((i + 1) % NUM_REGS),
                  reg_addr_t'((i + 2) % NUM_REGS));
        end

        // ---------------- report ----------------
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule : tb_reg_file
